pipeline_hazard_ctrl: RTL and testbench

Hazard sequencer for the 5-stage pipeline. It sits beside the forwarding unit and decides, per cycle, whether PC and IF/ID advance, hold or flush. It covers three cases: load-use hazards that forwarding cannot resolve, taken branches/jumps resolved in EX, and a multi-cycle multiply/divide unit whose HI/LO results younger instructions must wait for. It owns the mult/div busy counter and an explicit RUN/MD_BUSY state machine.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 29 ++
 rtl/md_busy_timer.sv | 76 +++++++
 rtl/pipeline_hazard_ctrl.sv | 113 +++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
//==============================================================================
// Package : pipeline_hazard_ctrl_pkg
// Brief   : Shared encodings and defaults for the pipeline hazard sequencer.
// Rev     : 1.0  initial release
//==============================================================================
`default_nettype none

package pipeline_hazard_ctrl_pkg;

    typedef enum logic [0:0] {
        HZ_RUN     = 1'b0,
        HZ_MD_BUSY = 1'b1
    } hz_state_e;

    localparam logic [4:0] REG_ZERO      = 5'd0;
    localparam int         MD_CYCLES_DEF = 32;
    localparam int         CNT_W_DEF     = 6;

    // A register read matches a producer only when the read is real and the
    // destination is not the hard-wired zero register.
    function automatic logic reg_match(input logic       uses,
                                       input logic [4:0] src,
                                       input logic [4:0] dst);
        return uses && (dst != REG_ZERO) && (src == dst);
    endfunction

endpackage

`default_nettype wire

// File: rtl/md_busy_timer.sv
//==============================================================================
// Module : md_busy_timer
// Brief  : RUN/MD_BUSY sequencer and down-counter for the multi-cycle mult/div.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module md_busy_timer
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int MD_CYCLES = MD_CYCLES_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_start,
    output logic o_busy,
    output logic o_done
);

    localparam logic [CNT_W-1:0] c_RELOAD = CNT_W'(MD_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_ONE    = CNT_W'(1);

    hz_state_e        r_state_q, w_state_d;
    logic [CNT_W-1:0] r_cnt_q,   w_cnt_d;
    logic             r_done_q,  w_done_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q <= HZ_RUN;
            r_cnt_q   <= '0;
            r_done_q  <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_cnt_q   <= w_cnt_d;
            r_done_q  <= w_done_d;
        end
    end

    // A start while busy is dropped on purpose: the counter keeps the
    // operation already in flight.
    always_comb begin
        w_state_d = r_state_q;
        w_cnt_d   = r_cnt_q;
        w_done_d  = 1'b0;
        case (r_state_q)
            HZ_RUN: begin
                if (i_start) begin
                    w_state_d = HZ_MD_BUSY;
                    w_cnt_d   = c_RELOAD;
                end
            end
            HZ_MD_BUSY: begin
                if (r_cnt_q != '0) begin
                    w_cnt_d = r_cnt_q - c_ONE;
                end else begin
                    w_done_d  = 1'b1;
                    w_state_d = HZ_RUN;
                end
            end
            default: w_state_d = HZ_RUN;
        endcase
    end

    assign o_busy = (r_state_q == HZ_MD_BUSY);
    assign o_done = r_done_q;

`ifndef SYNTHESIS
    a_no_start_while_busy: assert property (
        @(posedge clk) disable iff (!rst_n) !((r_state_q == HZ_MD_BUSY) && i_start)
    );
`endif

endmodule

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
//==============================================================================
// Module : pipeline_hazard_ctrl
// Brief  : Per-cycle advance/hold/flush decision for the 5-stage pipeline.
// Config : define HAZARD_PERF_EN to add load/md stall and flush cycle counters.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int MD_CYCLES = MD_CYCLES_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  IF_ID_rs,
    input  logic [4:0]  IF_ID_rt,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic        id_uses_hilo,
    input  logic        id_is_md,
    input  logic        ID_Ex_MemRead,
    input  logic [4:0]  ID_Ex_rt,
    input  logic        ex_md_start,
    input  logic        ex_branch_taken,
    output logic        PC_Wr,
    output logic        IF_ID_Wr,
    output logic        IF_ID_Flush,
    output logic        ID_Ex_Flush,
    output logic        md_busy,
    output logic        md_done
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0] load_stall_cnt,
    output logic [31:0] md_stall_cnt,
    output logic [31:0] flush_cnt
`endif
);

    logic w_load_hz;
    logic w_md_hz;

    md_busy_timer #(
        .MD_CYCLES (MD_CYCLES),
        .CNT_W     (CNT_W)
    ) u_md_busy_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (ex_md_start),
        .o_busy  (md_busy),
        .o_done  (md_done)
    );

    assign w_load_hz = ID_Ex_MemRead &&
                       (reg_match(id_uses_rs, IF_ID_rs, ID_Ex_rt) ||
                        reg_match(id_uses_rt, IF_ID_rt, ID_Ex_rt));
    assign w_md_hz   = md_busy && (id_uses_hilo || id_is_md);

    // A taken branch beats any stall: the stalled instruction is wrong-path.
    always_comb begin
        PC_Wr       = 1'b1;
        IF_ID_Wr    = 1'b1;
        IF_ID_Flush = 1'b0;
        ID_Ex_Flush = 1'b0;
        if (ex_branch_taken) begin
            IF_ID_Flush = 1'b1;
            ID_Ex_Flush = 1'b1;
        end else if (w_load_hz || w_md_hz) begin
            PC_Wr       = 1'b0;
            IF_ID_Wr    = 1'b0;
            ID_Ex_Flush = 1'b1;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] r_load_cnt_q,  w_load_cnt_d;
    logic [31:0] r_md_cnt_q,    w_md_cnt_d;
    logic [31:0] r_flush_cnt_q, w_flush_cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_load_cnt_q  <= '0;
            r_md_cnt_q    <= '0;
            r_flush_cnt_q <= '0;
        end else begin
            r_load_cnt_q  <= w_load_cnt_d;
            r_md_cnt_q    <= w_md_cnt_d;
            r_flush_cnt_q <= w_flush_cnt_d;
        end
    end

    // Counters saturate rather than wrap so long runs stay meaningful.
    always_comb begin
        w_load_cnt_d  = r_load_cnt_q;
        w_md_cnt_d    = r_md_cnt_q;
        w_flush_cnt_d = r_flush_cnt_q;
        if (ex_branch_taken) begin
            if (r_flush_cnt_q != '1) w_flush_cnt_d = r_flush_cnt_q + 32'd1;
        end else begin
            if (w_load_hz && (r_load_cnt_q != '1)) w_load_cnt_d = r_load_cnt_q + 32'd1;
            if (w_md_hz   && (r_md_cnt_q   != '1)) w_md_cnt_d   = r_md_cnt_q   + 32'd1;
        end
    end

    assign load_stall_cnt = r_load_cnt_q;
    assign md_stall_cnt   = r_md_cnt_q;
    assign flush_cnt      = r_flush_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
//==============================================================================
// Module : tb_pipeline_hazard_ctrl
// Brief  : Self-checking bench for pipeline_hazard_ctrl (MD_CYCLES 32 and 1).
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] IF_ID_rs, IF_ID_rt, ID_Ex_rt;
    logic       id_uses_rs, id_uses_rt, id_uses_hilo, id_is_md;
    logic       ID_Ex_MemRead, ex_md_start, ex_branch_taken;

    logic pc_wr [2], ifid_wr [2], ifid_fl [2], idex_fl [2], md_busy [2], md_done [2];
`ifdef HAZARD_PERF_EN
    logic [31:0] ls_cnt [2], ms_cnt [2], fl_cnt [2];
`endif

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.MD_CYCLES(32), .CNT_W(6)) dut0 (
        .clk(clk), .rst_n(rst_n), .IF_ID_rs(IF_ID_rs), .IF_ID_rt(IF_ID_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_uses_hilo(id_uses_hilo),
        .id_is_md(id_is_md), .ID_Ex_MemRead(ID_Ex_MemRead), .ID_Ex_rt(ID_Ex_rt),
        .ex_md_start(ex_md_start), .ex_branch_taken(ex_branch_taken),
        .PC_Wr(pc_wr[0]), .IF_ID_Wr(ifid_wr[0]), .IF_ID_Flush(ifid_fl[0]),
        .ID_Ex_Flush(idex_fl[0]), .md_busy(md_busy[0]), .md_done(md_done[0])
`ifdef HAZARD_PERF_EN
        , .load_stall_cnt(ls_cnt[0]), .md_stall_cnt(ms_cnt[0]), .flush_cnt(fl_cnt[0])
`endif
    );

    pipeline_hazard_ctrl #(.MD_CYCLES(1), .CNT_W(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .IF_ID_rs(IF_ID_rs), .IF_ID_rt(IF_ID_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_uses_hilo(id_uses_hilo),
        .id_is_md(id_is_md), .ID_Ex_MemRead(ID_Ex_MemRead), .ID_Ex_rt(ID_Ex_rt),
        .ex_md_start(ex_md_start), .ex_branch_taken(ex_branch_taken),
        .PC_Wr(pc_wr[1]), .IF_ID_Wr(ifid_wr[1]), .IF_ID_Flush(ifid_fl[1]),
        .ID_Ex_Flush(idex_fl[1]), .md_busy(md_busy[1]), .md_done(md_done[1])
`ifdef HAZARD_PERF_EN
        , .load_stall_cnt(ls_cnt[1]), .md_stall_cnt(ms_cnt[1]), .flush_cnt(fl_cnt[1])
`endif
    );

    // Reference model: remaining busy cycles per instance.
    int n_cmp = 0;
    int n_bad = 0;
    int mdc [2] = '{32, 1};
    int busy_left [2];
    bit done_m [2];
    longint ls_m [2], ms_m [2], fl_m [2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit model_load_hz();
        return ID_Ex_MemRead && (ID_Ex_rt != 5'd0) &&
               ((id_uses_rs && IF_ID_rs == ID_Ex_rt) || (id_uses_rt && IF_ID_rt == ID_Ex_rt));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            busy_left[i] = 0; done_m[i] = 0; ls_m[i] = 0; ms_m[i] = 0; fl_m[i] = 0;
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 2; i++) begin
            bit lhz, mhz, stall;
            lhz   = model_load_hz();
            mhz   = (busy_left[i] > 0) && (id_uses_hilo || id_is_md);
            stall = !ex_branch_taken && (lhz || mhz);
            chk($sformatf("d%0d_PC_Wr", i),       32'(pc_wr[i]),   32'(!stall));
            chk($sformatf("d%0d_IF_ID_Wr", i),    32'(ifid_wr[i]), 32'(!stall));
            chk($sformatf("d%0d_IF_ID_Flush", i), 32'(ifid_fl[i]), 32'(ex_branch_taken));
            chk($sformatf("d%0d_ID_Ex_Flush", i), 32'(idex_fl[i]), 32'(ex_branch_taken || stall));
            chk($sformatf("d%0d_md_busy", i),     32'(md_busy[i]), 32'(busy_left[i] > 0));
            chk($sformatf("d%0d_md_done", i),     32'(md_done[i]), 32'(done_m[i]));
`ifdef HAZARD_PERF_EN
            chk($sformatf("d%0d_load_stall_cnt", i), ls_cnt[i], 32'(ls_m[i]));
            chk($sformatf("d%0d_md_stall_cnt", i),   ms_cnt[i], 32'(ms_m[i]));
            chk($sformatf("d%0d_flush_cnt", i),      fl_cnt[i], 32'(fl_m[i]));
`endif
        end
    endtask

    task automatic model_edge();
        bit lhz;
        lhz = model_load_hz();
        for (int i = 0; i < 2; i++) begin
            bit mhz;
            mhz = (busy_left[i] > 0) && (id_uses_hilo || id_is_md);
            if (ex_branch_taken) fl_m[i] = (fl_m[i] < 64'hFFFF_FFFF) ? fl_m[i] + 1 : fl_m[i];
            else begin
                if (lhz) ls_m[i] = (ls_m[i] < 64'hFFFF_FFFF) ? ls_m[i] + 1 : ls_m[i];
                if (mhz) ms_m[i] = (ms_m[i] < 64'hFFFF_FFFF) ? ms_m[i] + 1 : ms_m[i];
            end
            done_m[i] = 0;
            if (busy_left[i] > 0) begin
                busy_left[i]--;
                if (busy_left[i] == 0) done_m[i] = 1;
            end else if (ex_md_start) begin
                busy_left[i] = mdc[i];
            end
        end
    endtask

    // Called 1ns after a rising edge with inputs already driven.
    task automatic step();
        #1 compare_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_idle();
        IF_ID_rs = 0; IF_ID_rt = 0; ID_Ex_rt = 0;
        id_uses_rs = 0; id_uses_rt = 0; id_uses_hilo = 0; id_is_md = 0;
        ID_Ex_MemRead = 0; ex_md_start = 0; ex_branch_taken = 0;
    endtask

    initial begin
        int nb0, nb1, ndone0, issue0;
        set_idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_md_busy", 32'(md_busy[0]), 32'd0);
        chk("rst_md_done", 32'(md_done[0]), 32'd0);
        chk("rst_PC_Wr",   32'(pc_wr[0]),   32'd1);
        chk("rst_flush",   32'(idex_fl[0]), 32'd0);
        rst_n = 1'b1;
        #1;

        // Load-use stalls through rs, rt, then rs again.
        ID_Ex_MemRead = 1; ID_Ex_rt = 8; IF_ID_rs = 8; id_uses_rs = 1;
        #1 chk("ld_PC_Wr", 32'(pc_wr[0]), 32'd0);
        chk("ld_IF_ID_Wr", 32'(ifid_wr[0]), 32'd0);
        chk("ld_ID_Ex_Flush", 32'(idex_fl[0]), 32'd1);
        chk("ld_IF_ID_Flush", 32'(ifid_fl[0]), 32'd0);
        step();
        id_uses_rs = 0; IF_ID_rs = 3; IF_ID_rt = 8; id_uses_rt = 1;
        step();
        id_uses_rt = 0; IF_ID_rs = 8; id_uses_rs = 1;
        step();
        ID_Ex_rt = 0; IF_ID_rs = 0;
        #1 chk("ld_r0_PC_Wr", 32'(pc_wr[0]), 32'd1);
        step();

        // Branch overrides the same load hazard, twice.
        ID_Ex_rt = 8; IF_ID_rs = 8; ex_branch_taken = 1;
        #1 chk("br_IF_ID_Flush", 32'(ifid_fl[0]), 32'd1);
        chk("br_ID_Ex_Flush", 32'(idex_fl[0]), 32'd1);
        chk("br_PC_Wr", 32'(pc_wr[0]), 32'd1);
        step();
        step();
        set_idle();
`ifdef HAZARD_PERF_EN
        #1 chk("perf_load", ls_cnt[0], 32'd3);
        chk("perf_md", ms_cnt[0], 32'd0);
        chk("perf_flush", fl_cnt[0], 32'd2);
`endif

        // Mult/div timing with an mflo waiting in ID.
        ex_md_start = 1; id_uses_hilo = 1;
        step();
        ex_md_start = 0;
        nb0 = 0; nb1 = 0; ndone0 = 0; issue0 = 0;
        for (int k = 1; k <= 33; k++) begin
            if (k == 33) ex_md_start = 1;
            #1;
            if (md_busy[0]) nb0++;
            if (md_busy[1]) nb1++;
            if (md_done[0]) ndone0 = k;
            if (pc_wr[0]) issue0 = issue0 + k;
            step();
        end
        chk("md_busy_cycles", 32'(nb0), 32'd32);
        chk("md_done_cycle", 32'(ndone0), 32'd33);
        chk("mflo_issue_cycle", 32'(issue0), 32'd33);
        chk("md1_busy_cycles", 32'(nb1), 32'd1);
        ex_md_start = 0;
        #1 chk("b2b_busy", 32'(md_busy[0]), 32'd1);
        // Cycle 34 holds counter 31; run to the cycle where it reads 10.
        for (int k = 34; k < 55; k++) step();
        #1 rst_n = 1'b0;
        #1 chk("rst_mid_busy", 32'(md_busy[0]), 32'd0);
        model_reset();
        #1 rst_n = 1'b1;
        for (int k = 0; k < 40; k++) begin
            #1 chk("rst_mid_no_done", 32'(md_done[0]), 32'd0);
            step();
        end

        // Randomized traffic.
        for (int n = 0; n < 4000; n++) begin
            IF_ID_rs        = 5'($urandom_range(0, 3));
            IF_ID_rt        = 5'($urandom_range(0, 3));
            ID_Ex_rt        = 5'($urandom_range(0, 3));
            id_uses_rs      = 1'($urandom);
            id_uses_rt      = 1'($urandom);
            id_uses_hilo    = ($urandom_range(0, 3) == 0);
            id_is_md        = ($urandom_range(0, 5) == 0);
            ID_Ex_MemRead   = ($urandom_range(0, 2) == 0);
            ex_branch_taken = ($urandom_range(0, 7) == 0);
            ex_md_start     = (busy_left[0] == 0) && (busy_left[1] == 0) &&
                              ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 499) == 0) begin
                rst_n = 1'b0;
                #1 model_reset();
                rst_n = 1'b1;
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
